// File: rtl/coor_pkg.sv
// Shared widths, packed coordinate layout and skid-buffer state type for the
// coordinate decoder slice.
package coor_pkg;

    localparam int COOR_W  = 16;
    localparam int IDX_W   = 32;
    localparam int ROW_MSB = 31;
    localparam int ROW_LSB = 16;
    localparam int COL_MSB = 15;
    localparam int COL_LSB = 0;

    // Packed order puts row in [31:16] and col in [15:0] of the output word.
    typedef struct packed {
        logic [COOR_W-1:0] row;
        logic [COOR_W-1:0] col;
    } coord_t;

    typedef struct packed {
        coord_t coord;
        logic   tuser;
        logic   tlast;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

    function automatic logic [IDX_W-1:0] pack_coord(input coord_t c);
        return {c.row, c.col};
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI4-Stream skid buffer: registered ready, one-cycle latency,
// full throughput, payload held stable while the consumer stalls.
module axis_skid_buf
    import coor_pkg::*;
#(
    parameter int W = BEAT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         s_valid_i,
    input  logic [W-1:0] s_data_i,
    output logic         s_ready_o,
    output logic         m_valid_o,
    output logic [W-1:0] m_data_o,
    input  logic         m_ready_i
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         ready_q, ready_d;
    logic         push, pop;

    assign push      = s_valid_i & ready_q;
    assign pop       = m_valid_o & m_ready_i;
    assign m_valid_o = (state_q != SKID_EMPTY);
    assign m_data_o  = slot0_q;
    assign s_ready_o = ready_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    slot0_d = s_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                unique case ({push, pop})
                    2'b10: begin
                        slot1_d = s_data_i;
                        state_d = SKID_FULL;
                    end
                    2'b11:   slot0_d = s_data_i;
                    2'b01:   state_d = SKID_EMPTY;
                    default: ;
                endcase
            end
            SKID_FULL: begin
                // Ready is low whenever FULL, so no push can arrive here.
                if (pop) begin
                    slot0_d = slot1_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        ready_d = (state_d != SKID_FULL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b0;
            // NOTE: the payload slots are reset because slot0 drives the output word directly.
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

endmodule

// File: rtl/coor_decoder.sv
// Linear-index to (row, col) decoder with sequence/framing checks and a skid-buffered
// AXI4-Stream video output. Optional err_cnt port under COOR_DECODER_ERR_CNT_EN.
module coor_decoder
    import coor_pkg::*;
#(
    parameter int ROW = 4,
    parameter int COL = 6
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_aresetn,
    input  logic             s_axis_tvalid,
    input  logic [IDX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             m_axis_tvalid,
    output logic [IDX_W-1:0] m_axis_tdata,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    input  logic             err_clr,
    output logic             seq_err,
    output logic             tlast_err,
`ifdef COOR_DECODER_ERR_CNT_EN
    output logic [15:0]      err_cnt,
`endif
    output logic             frame_done
);

    localparam logic [COOR_W-1:0] ROW_LAST = COOR_W'(ROW - 1);
    localparam logic [COOR_W-1:0] COL_LAST = COOR_W'(COL - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ROW) * IDX_W'(COL) - IDX_W'(1);

    logic [COOR_W-1:0] row_c_q, row_c_d;
    logic [COOR_W-1:0] col_c_q, col_c_d;
    logic [IDX_W-1:0]  exp_idx_q, exp_idx_d;
    logic              seq_err_q, seq_err_d;
    logic              tlast_err_q, tlast_err_d;
    logic              accept, exp_last, seq_hit, tlast_hit;
    beat_t             beat_in, beat_out;

    assign accept    = s_axis_tvalid & s_axis_tready;
    assign exp_last  = (exp_idx_q == IDX_LAST);
    assign seq_hit   = accept & (s_axis_tdata != exp_idx_q);
    assign tlast_hit = accept & (s_axis_tlast != exp_last);

    always_comb begin
        row_c_d   = row_c_q;
        col_c_d   = col_c_q;
        exp_idx_d = exp_idx_q;
        if (accept) begin
            if (s_axis_tlast) begin
                // Any tlast resyncs the frame, which recovers from an early tlast.
                row_c_d   = '0;
                col_c_d   = '0;
                exp_idx_d = '0;
            end else begin
                if (col_c_q == COL_LAST) begin
                    col_c_d = '0;
                    row_c_d = (row_c_q == ROW_LAST) ? '0 : row_c_q + COOR_W'(1);
                end else begin
                    col_c_d = col_c_q + COOR_W'(1);
                end
                exp_idx_d = exp_last ? '0 : exp_idx_q + IDX_W'(1);
            end
        end
        // A fresh error outranks a simultaneous clear.
        seq_err_d   = seq_hit   | (seq_err_q   & ~err_clr);
        tlast_err_d = tlast_hit | (tlast_err_q & ~err_clr);
    end

    always_comb begin
        beat_in.coord.row = row_c_q;
        beat_in.coord.col = col_c_q;
        beat_in.tuser     = (row_c_q == '0) && (col_c_q == '0);
        beat_in.tlast     = (col_c_q == COL_LAST);
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            row_c_q     <= '0;
            col_c_q     <= '0;
            exp_idx_q   <= '0;
            seq_err_q   <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            row_c_q     <= row_c_d;
            col_c_q     <= col_c_d;
            exp_idx_q   <= exp_idx_d;
            seq_err_q   <= seq_err_d;
            tlast_err_q <= tlast_err_d;
        end
    end

    axis_skid_buf #(
        .W(BEAT_W)
    ) u_skid (
        .clk_i    (s_axis_aclk),
        .rst_ni   (s_axis_aresetn),
        .s_valid_i(s_axis_tvalid),
        .s_data_i (beat_in),
        .s_ready_o(s_axis_tready),
        .m_valid_o(m_axis_tvalid),
        .m_data_o (beat_out),
        .m_ready_i(m_axis_tready)
    );

    assign m_axis_tdata = pack_coord(beat_out.coord);
    assign m_axis_tuser = beat_out.tuser;
    assign m_axis_tlast = beat_out.tlast;
    assign seq_err      = seq_err_q;
    assign tlast_err    = tlast_err_q;
    assign frame_done   = m_axis_tvalid & m_axis_tready &
                          (beat_out.coord.row == ROW_LAST) & (beat_out.coord.col == COL_LAST);

`ifdef COOR_DECODER_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        any_hit;

    assign any_hit = seq_hit | tlast_hit;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = {15'd0, any_hit};
        end else if (any_hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
